filter_load_sequencer: RTL
==========================

Name: filter_load_sequencer

Overview:
Parametrised control FSM for the UART-fed filter datapath. It counts received bytes (rx_done_tick) into NUM_LOAD operand registers via one-hot load enables, clears the accumulator, then steps a tap select through NUM_TAPS multiply-accumulate cycles and pulses listo. It sits between the UART receiver and the filter register/mux/accumulator datapath, replacing fixed 4-enable, fixed-select controllers with a generalised, overrun-aware sequencer.

Parameters:
NUM_LOAD, 4, number of operand registers loaded from consecutive rx bytes (>=1)
NUM_TAPS, 5, number of MAC steps per computation (>=1)
TAP_SEL_W, 3, tap select width; must be >= clog2(NUM_TAPS), minimum 1
TIMEOUT_CYC, 1000, idle cycles allowed between bytes of one frame (only used with FLS_LOAD_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
rx_done_tick  in  1  one-cycle strobe, UART byte received
en  out  NUM_LOAD  one-hot load enables, bit i loads operand register i
acc_clr  out  1  accumulator clear strobe
acc_en  out  1  accumulate enable
tap_sel  out  TAP_SEL_W  coefficient/operand mux select during compute
busy  out  1  high from CLR through DONE
listo  out  1  one-cycle result-valid strobe
err_ovr  out  1  one-cycle pulse: tick dropped while busy
err_to  out  1  one-cycle pulse: load frame abandoned on timeout (0 without macro)

Behaviour:
- All outputs registered. On reset low (any time, mid-operation included): state=LOAD, byte index=0, tap counter=0, every output 0. First activity is evaluated at the first rising edge after reset goes high.
- States: LOAD -> CLR -> COMP -> DONE -> LOAD.
- LOAD: a tick sampled at edge k with index i sets en[i]=1 for exactly the cycle after edge k. All other en bits stay 0. Index increments.
- If i==NUM_LOAD-1 at that edge, index wraps to 0 and state goes to CLR.
- No tick: en=0 and the state holds.
- CLR: acc_clr=1 and busy=1 for one cycle, with tap_sel=0.
- COMP: NUM_TAPS consecutive cycles with acc_en=1 and busy=1. tap_sel=0,1,...,NUM_TAPS-1, one value per cycle, zero-extended to TAP_SEL_W.
- DONE: listo=1 and busy=1 for one cycle. Then LOAD with index=0.
- Latency: listo is high exactly NUM_TAPS+2 cycles after the cycle en[NUM_LOAD-1] is high.
- Ticks sampled in CLR, COMP or DONE are dropped. Each one gives err_ovr=1 the following cycle. Index, tap counter and sequence are unaffected.
- Simultaneous events: in DONE the return to LOAD takes priority, so a tick in DONE is dropped and flagged. A tick in the same edge as the LOAD->CLR transition is the accepted last byte, not an overrun.
- NUM_LOAD=1: every accepted tick immediately starts a computation.
- NUM_TAPS=1: COMP lasts one cycle with tap_sel=0.
- acc_clr and acc_en are never high together. en is zero outside LOAD.

Optional Feature:
FLS_LOAD_TIMEOUT_EN
- Defined:
  - While in LOAD with index>0, an idle counter increments each cycle without a tick and reloads to 0 on every tick.
  - When it reaches TIMEOUT_CYC, index returns to 0, the counter clears, and err_to pulses one cycle.
  - A tick in that same cycle wins: it is accepted and no timeout fires.
  - Counter width is clog2(TIMEOUT_CYC+1).
- Not defined: no counter exists, err_to is tied 0, and a partial frame waits indefinitely.

Test Plan:
1. Defaults; 4 ticks spaced 3 cycles -> en=0001,0010,0100,1000 each one cycle after its tick; then acc_clr 1 cycle; acc_en 5 cycles with tap_sel 0,1,2,3,4; listo 1 cycle, 7 cycles after en=1000; busy high for 7 cycles; err_ovr never high.
2. rx_done_tick held high continuously from reset release -> en walks 0001..1000 on consecutive cycles; err_ovr high every cycle for 7 cycles (CLR..DONE); after listo, en=0001 next cycle and the pattern repeats.
3. reset driven low during COMP at tap_sel=2 -> all outputs 0 immediately (asynchronous); after release, 4 new ticks produce a full clean sequence starting at en=0001.
4. With FLS_LOAD_TIMEOUT_EN and TIMEOUT_CYC=20: 2 ticks, then 20 idle cycles -> err_to pulse; next tick produces en=0001. A tick arriving exactly on the 20th idle cycle produces en=0100 and no err_to. Without the macro: 2 ticks, 100 idle, 2 ticks -> en=0100, 1000, then compute.
5. NUM_LOAD=8, NUM_TAPS=3, TAP_SEL_W=2 -> 8 ticks walk en bit 0..7; acc_en 3 cycles with tap_sel 0,1,2; listo 5 cycles after en[7].
6. NUM_LOAD=1, NUM_TAPS=1 -> each accepted tick gives en=1, acc_clr, acc_en with tap_sel=0, and listo on 4 consecutive cycles; a tick 2 cycles after the first is flagged by err_ovr.

Source files
------------

// File: rtl/filter_load_sequencer.sv
`timescale 1ns/1ps
// Byte-load / clear / multiply-accumulate control sequencer for the UART-fed filter datapath.
// Define FLS_LOAD_TIMEOUT_EN to abandon a partial load frame after TIMEOUT_CYC idle cycles.
module filter_load_sequencer #(
    parameter int unsigned NUM_LOAD    = 4,
    parameter int unsigned NUM_TAPS    = 5,
    parameter int unsigned TAP_SEL_W   = 3,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_done_tick,
    output logic [NUM_LOAD-1:0]  en,
    output logic                 acc_clr,
    output logic                 acc_en,
    output logic [TAP_SEL_W-1:0] tap_sel,
    output logic                 busy,
    output logic                 listo,
    output logic                 err_ovr,
    output logic                 err_to
);

    localparam int unsigned IDX_W = (NUM_LOAD > 1) ? $clog2(NUM_LOAD) : 1;
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_LOAD - 1);
    localparam logic [TAP_SEL_W-1:0] TAP_LAST = TAP_SEL_W'(NUM_TAPS - 1);

    if (NUM_LOAD < 1) begin : g_bad_num_load
        $error("NUM_LOAD must be at least 1");
    end
    if (NUM_TAPS < 1) begin : g_bad_num_taps
        $error("NUM_TAPS must be at least 1");
    end
    if ((TAP_SEL_W < 1) || (TAP_SEL_W < $clog2(NUM_TAPS))) begin : g_bad_tap_sel_w
        $error("TAP_SEL_W too narrow for NUM_TAPS");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_CLR  = 2'd1,
        S_COMP = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e               state_q,   state_d;
    logic [IDX_W-1:0]     idx_q,     idx_d;
    logic [TAP_SEL_W-1:0] tap_q,     tap_d;
    logic [NUM_LOAD-1:0]  en_q,      en_d;
    logic                 acc_clr_q, acc_clr_d;
    logic                 acc_en_q,  acc_en_d;
    logic [TAP_SEL_W-1:0] tap_sel_q, tap_sel_d;
    logic                 busy_q,    busy_d;
    logic                 listo_q,   listo_d;
    logic                 err_ovr_q, err_ovr_d;

`ifdef FLS_LOAD_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_to_q, err_to_d;
`endif

    // Outputs are registered decodes of the internal state, so they trail it by one cycle.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tap_d     = tap_q;
        en_d      = '0;
        acc_clr_d = 1'b0;
        acc_en_d  = 1'b0;
        tap_sel_d = '0;
        busy_d    = 1'b0;
        listo_d   = 1'b0;
        err_ovr_d = rx_done_tick && (state_q != S_LOAD);
`ifdef FLS_LOAD_TIMEOUT_EN
        cnt_d     = '0;
        err_to_d  = 1'b0;
`endif
        unique case (state_q)
            S_LOAD: begin
                if (rx_done_tick) begin
                    en_d = NUM_LOAD'(1) << idx_q;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = S_CLR;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
`ifdef FLS_LOAD_TIMEOUT_EN
                // A tick in the limit cycle takes the branch above, so it beats the timeout.
                else if (idx_q != '0) begin
                    if (cnt_q == CNT_LIMIT) begin
                        idx_d    = '0;
                        err_to_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`endif
            end
            S_CLR: begin
                acc_clr_d = 1'b1;
                busy_d    = 1'b1;
                tap_d     = '0;
                state_d   = S_COMP;
            end
            S_COMP: begin
                acc_en_d  = 1'b1;
                busy_d    = 1'b1;
                tap_sel_d = tap_q;
                if (tap_q == TAP_LAST) begin
                    tap_d   = '0;
                    state_d = S_DONE;
                end else begin
                    tap_d = tap_q + TAP_SEL_W'(1);
                end
            end
            S_DONE: begin
                listo_d = 1'b1;
                busy_d  = 1'b1;
                idx_d   = '0;
                state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_LOAD;
            idx_q     <= '0;
            tap_q     <= '0;
            en_q      <= '0;
            acc_clr_q <= 1'b0;
            acc_en_q  <= 1'b0;
            tap_sel_q <= '0;
            busy_q    <= 1'b0;
            listo_q   <= 1'b0;
            err_ovr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tap_q     <= tap_d;
            en_q      <= en_d;
            acc_clr_q <= acc_clr_d;
            acc_en_q  <= acc_en_d;
            tap_sel_q <= tap_sel_d;
            busy_q    <= busy_d;
            listo_q   <= listo_d;
            err_ovr_q <= err_ovr_d;
        end
    end

`ifdef FLS_LOAD_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            err_to_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            err_to_q <= err_to_d;
        end
    end

    assign err_to = err_to_q;
`else
    assign err_to = 1'b0;
`endif

    assign en      = en_q;
    assign acc_clr = acc_clr_q;
    assign acc_en  = acc_en_q;
    assign tap_sel = tap_sel_q;
    assign busy    = busy_q;
    assign listo   = listo_q;
    assign err_ovr = err_ovr_q;

endmodule
